// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: load extraction, read-data hold, WB/ID buses
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ex_to_mem_valid,
  input  logic [156:0] ex_to_mem_bus,
  output logic         mem_allowin,
  input  logic [31:0]  data_sram_rdata,
  input  logic         wb_allowin,
  output logic         mem_to_wb_valid,
  output logic [150:0] mem_to_wb_bus,
  output logic [38:0]  mem_to_id_bus,
  input  logic         ertn_flush
);

  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic [1:0]  addr_lo;
    logic        op_b;
    logic        op_h;
    logic        op_u;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic        ertn_flush;
  } ex_mem_t;

  ex_mem_t     payload_q, payload_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic        rdata_buf_vld_q, rdata_buf_vld_d;

  logic        mem_ready_go;
  logic        leave;
  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_result;
  logic [31:0] rf_wdata;
  logic        out_rf_we;

  // Single-cycle stage: it can always hand on what it holds.
  assign mem_ready_go    = 1'b1;
  assign mem_allowin     = ~mem_valid_q | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid_q;
  assign leave           = mem_valid_q & mem_ready_go & wb_allowin;

  // Next-state for the valid bit, payload latch and the SRAM read-data hold buffer.
  always_comb begin
    mem_valid_d     = mem_valid_q;
    payload_d       = payload_q;
    rdata_buf_d     = rdata_buf_q;
    rdata_buf_vld_d = rdata_buf_vld_q;

    if (ertn_flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_to_mem_valid;
    end

    if (ex_to_mem_valid & mem_allowin) begin
      payload_d = ex_to_mem_bus;
    end

    // SRAM data is only valid in the first cycle of a load; keep a copy for stalls.
    if (mem_valid_q & payload_q.res_from_mem & ~rdata_buf_vld_q) begin
      rdata_buf_d     = data_sram_rdata;
      rdata_buf_vld_d = 1'b1;
    end
    if (leave | ertn_flush) begin
      rdata_buf_vld_d = 1'b0;
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q     <= 1'b0;
      payload_q       <= '0;
      rdata_buf_q     <= 32'd0;
      rdata_buf_vld_q <= 1'b0;
    end else begin
      mem_valid_q     <= mem_valid_d;
      payload_q       <= payload_d;
      rdata_buf_q     <= rdata_buf_d;
      rdata_buf_vld_q <= rdata_buf_vld_d;
    end
  end

  // Byte/half selection and sign or zero extension of the load word.
  always_comb begin
    rd_word = rdata_buf_vld_q ? rdata_buf_q : data_sram_rdata;
    case (payload_q.addr_lo)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = payload_q.addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    if (payload_q.op_b) begin
      load_result = {{24{~payload_q.op_u & ld_byte[7]}}, ld_byte};
    end else if (payload_q.op_h) begin
      load_result = {{16{~payload_q.op_u & ld_half[15]}}, ld_half};
    end else begin
      load_result = rd_word;
    end

    rf_wdata = payload_q.res_from_mem ? load_result : payload_q.alu_result;
  end

  // Output buses; write enables are gated so an empty stage never looks like a write.
  always_comb begin
    out_rf_we     = payload_q.rf_we & mem_valid_q;
    mem_to_wb_bus = {payload_q.pc,
                     out_rf_we,
                     payload_q.rf_waddr,
                     rf_wdata,
                     payload_q.csr_re,
                     payload_q.csr_we & mem_valid_q,
                     payload_q.csr_num,
                     payload_q.csr_wmask,
                     payload_q.rkd_value,
                     payload_q.ertn_flush & mem_valid_q};
    mem_to_id_bus = {out_rf_we,
                     payload_q.rf_waddr,
                     rf_wdata,
                     payload_q.csr_re & mem_valid_q};
  end

endmodule
